// File: rtl/data_sram_confreg_if.sv
// CPU data SRAM port bundle: request (en/we/addr/wdata) from the CPU, 1-cycle-latency rdata back.
// Handshake: no valid/ready pair; a request is accepted on every posedge with en=1, and rdata answers it on the following cycle.
interface data_sram_confreg_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    output data_sram_rdata
  );
endinterface

// File: rtl/data_sram_confreg.sv
// MMIO config register file on the CPU data SRAM port: CRs, timer, LEDs, switches, numeric display.
// Optional timer compare/interrupt is enabled by defining CONFREG_TIMER_IRQ_EN.
module data_sram_confreg #(
  parameter logic [31:0] ADDR_BASE = 32'hbfaf_0000,
  parameter logic        SIMU      = 1'b1,
  parameter int          SW_W      = 8
) (
  input  logic              clk,
  input  logic              resetn,
  data_sram_confreg_if.slave bus,
  input  logic [SW_W-1:0]   switch,
  output logic [15:0]       led,
  output logic [31:0]       num_data,
  output logic              timer_irq
);

  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return res;
  endfunction

  logic [31:0]     r_cr [8];
  logic [31:0]     r_timer;
  logic [15:0]     r_led;
  logic [31:0]     r_num;
  logic [SW_W-1:0] r_sw_s1;
  logic [SW_W-1:0] r_sw_s2;
  logic [31:0]     r_rdata;

  logic        w_sel;
  logic        w_wr;
  logic [15:0] w_off;
  logic [15:0] w_word;
  logic        w_is_cr;
  logic [31:0] w_rd_val;
  logic [31:0] w_timer_inc;
  logic [31:0] w_sw_ext;
  logic        w_unused_addr;

  assign w_sel   = bus.data_sram_en && (bus.data_sram_addr[31:16] == ADDR_BASE[31:16]);
  assign w_wr    = w_sel && (bus.data_sram_we != 4'b0000);
  assign w_off   = bus.data_sram_addr[15:0];
  assign w_word  = {w_off[15:2], 2'b00};
  assign w_is_cr = (w_off[15:5] == 11'h400);
  assign w_timer_inc = r_timer + 32'd1;
  assign w_sw_ext    = 32'(r_sw_s2);
  assign w_unused_addr = &{1'b0, bus.data_sram_addr[1:0]};

`ifdef CONFREG_TIMER_IRQ_EN
  logic [31:0] r_tcmp;
  logic        r_irq;
  logic        w_wr_tcmp;

  assign w_wr_tcmp = w_wr && (w_word == 16'he004);

  // Clear beats a coinciding compare hit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_tcmp <= 32'hffff_ffff;
      r_irq  <= 1'b0;
    end else begin
      if (w_wr_tcmp) r_tcmp <= f_merge(r_tcmp, bus.data_sram_wdata, bus.data_sram_we);
      r_irq <= w_wr_tcmp ? 1'b0 : (r_irq || (r_timer == r_tcmp));
    end
  end

  assign timer_irq = r_irq;
`else
  assign timer_irq = 1'b0;
`endif

  always_comb begin
    w_rd_val = 32'h0;
    if (w_is_cr) begin
      w_rd_val = r_cr[w_off[4:2]];
    end else begin
      case (w_word)
        16'he000: w_rd_val = r_timer;
`ifdef CONFREG_TIMER_IRQ_EN
        16'he004: w_rd_val = r_tcmp;
`endif
        16'hf020: w_rd_val = {16'h0, r_led};
        16'hf030: w_rd_val = w_sw_ext;
        16'hf050: w_rd_val = r_num;
        16'hffec: w_rd_val = {31'h0, SIMU};
        default:  w_rd_val = 32'h0;
      endcase
    end
  end

  // Read-first: rdata captures the value present at the request edge.
  always_ff @(posedge clk) begin
    if (!resetn) r_rdata <= 32'h0;
    else if (w_sel) r_rdata <= w_rd_val;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 8; i++) r_cr[i] <= 32'h0;
      r_timer <= 32'h0;
      r_led   <= 16'hffff;
      r_num   <= 32'h0;
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
    end else begin
      r_sw_s1 <= switch;
      r_sw_s2 <= r_sw_s1;
      for (int i = 0; i < 8; i++)
        if (w_wr && w_is_cr && (w_off[4:2] == 3'(i)))
          r_cr[i] <= f_merge(r_cr[i], bus.data_sram_wdata, bus.data_sram_we);
      // Unwritten timer lanes still advance.
      if (w_wr && (w_word == 16'he000))
        r_timer <= f_merge(w_timer_inc, bus.data_sram_wdata, bus.data_sram_we);
      else
        r_timer <= w_timer_inc;
      if (w_wr && (w_word == 16'hf020)) begin
        if (bus.data_sram_we[0]) r_led[7:0]  <= bus.data_sram_wdata[7:0];
        if (bus.data_sram_we[1]) r_led[15:8] <= bus.data_sram_wdata[15:8];
      end
      if (w_wr && (w_word == 16'hf050))
        r_num <= f_merge(r_num, bus.data_sram_wdata, bus.data_sram_we);
    end
  end

  assign bus.data_sram_rdata = r_rdata;
  assign led      = r_led;
  assign num_data = r_num;

endmodule

// File: tb/tb_data_sram_confreg.sv
// Directed bench for data_sram_confreg: register map, byte lanes, timer wrap, sync latency, reset.
// Builds with or without CONFREG_TIMER_IRQ_EN.
module tb_data_sram_confreg;
  localparam logic [31:0] BASE = 32'hbfaf_0000;

  logic        clk;
  logic        resetn;
  logic [7:0]  switch;
  logic [15:0] led;
  logic [31:0] num_data;
  logic        timer_irq;

  int n_checks;
  int n_pass;

  data_sram_confreg_if bus_if();

  data_sram_confreg #(.ADDR_BASE(BASE), .SIMU(1'b1), .SW_W(8)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus_if.slave),
    .switch    (switch),
    .led       (led),
    .num_data  (num_data),
    .timer_irq (timer_irq)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1 time unit after the edge, outputs are sampled there too.
  task automatic step(input logic en, input logic [3:0] we, input logic [31:0] addr,
                      input logic [31:0] wdata);
    bus_if.data_sram_en    = en;
    bus_if.data_sram_we    = we;
    bus_if.data_sram_addr  = addr;
    bus_if.data_sram_wdata = wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus_if.data_sram_en = 1'b0;
    bus_if.data_sram_we = 4'b0000;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    resetn   = 1'b0;
    switch   = 8'h00;
    bus_if.data_sram_en    = 1'b0;
    bus_if.data_sram_we    = 4'b0000;
    bus_if.data_sram_addr  = 32'h0;
    bus_if.data_sram_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;

    check("rst_rdata", bus_if.data_sram_rdata, 32'h0);
    check("rst_led", {16'h0, led}, 32'h0000_ffff);
    check("rst_num", num_data, 32'h0);
    check("rst_irq", {31'h0, timer_irq}, 32'h0);

    step(1'b1, 4'b0000, BASE | 32'hf020, 32'h0);
    check("rd_led_rst", bus_if.data_sram_rdata, 32'h0000_ffff);
    step(1'b1, 4'b0000, BASE | 32'h8000, 32'h0);
    check("rd_cr0_rst", bus_if.data_sram_rdata, 32'h0);

    step(1'b1, 4'b0101, BASE | 32'h800c, 32'h1122_3344);
    check("wr_cr3_old", bus_if.data_sram_rdata, 32'h0);
    step(1'b1, 4'b0000, BASE | 32'h800c, 32'h0);
    check("rd_cr3_lanes", bus_if.data_sram_rdata, 32'h0022_0044);
    idle(2);
    check("rdata_hold_idle", bus_if.data_sram_rdata, 32'h0022_0044);

    step(1'b1, 4'b1111, BASE | 32'hf020, 32'haabb_1234);
    check("led_out", {16'h0, led}, 32'h0000_1234);
    step(1'b1, 4'b0000, BASE | 32'hf020, 32'h0);
    check("rd_led", bus_if.data_sram_rdata, 32'h0000_1234);

    step(1'b1, 4'b1100, BASE | 32'hf050, 32'hdead_beef);
    check("num_out", num_data, 32'hdead_0000);
    step(1'b1, 4'b0000, BASE | 32'hf050, 32'h0);
    check("rd_num", bus_if.data_sram_rdata, 32'hdead_0000);

    step(1'b1, 4'b1111, BASE | 32'he000, 32'h1234_5678);
    step(1'b1, 4'b1111, BASE | 32'he000, 32'hffff_fffe);
    check("timer_rd_first", bus_if.data_sram_rdata, 32'h1234_5678);
    idle(3);
    step(1'b1, 4'b0000, BASE | 32'he000, 32'h0);
    check("timer_wrap", bus_if.data_sram_rdata, 32'h0000_0001);

    step(1'b1, 4'b1111, 32'h1c00_f020, 32'h0000_0000);
    check("unsel_hold", bus_if.data_sram_rdata, 32'h0000_0001);
    check("unsel_led", {16'h0, led}, 32'h0000_1234);

    step(1'b1, 4'b1111, BASE | 32'hf040, 32'hffff_ffff);
    check("unmapped_wr", bus_if.data_sram_rdata, 32'h0);
    step(1'b1, 4'b0000, BASE | 32'hf040, 32'h0);
    check("unmapped_rd", bus_if.data_sram_rdata, 32'h0);

    switch = 8'ha5;
    idle(2);
    step(1'b1, 4'b0000, BASE | 32'hf030, 32'h0);
    check("switch_a5", bus_if.data_sram_rdata, 32'h0000_00a5);
    switch = 8'h5a;
    idle(1);
    step(1'b1, 4'b0000, BASE | 32'hf030, 32'h0);
    check("switch_latency", bus_if.data_sram_rdata, 32'h0000_00a5);
    step(1'b1, 4'b0000, BASE | 32'hf030, 32'h0);
    check("switch_5a", bus_if.data_sram_rdata, 32'h0000_005a);

    step(1'b1, 4'b0000, BASE | 32'hffec, 32'h0);
    check("simu_flag", bus_if.data_sram_rdata, 32'h0000_0001);

    step(1'b1, 4'b1111, BASE | 32'h8000, 32'hcafe_0001);
    step(1'b1, 4'b0000, BASE | 32'h8000, 32'h0);
    check("b2b_rd1", bus_if.data_sram_rdata, 32'hcafe_0001);
    step(1'b1, 4'b1111, BASE | 32'h8000, 32'h0bad_f00d);
    check("b2b_wr2_old", bus_if.data_sram_rdata, 32'hcafe_0001);
    step(1'b1, 4'b0000, BASE | 32'h8000, 32'h0);
    check("b2b_rd2", bus_if.data_sram_rdata, 32'h0bad_f00d);

    step(1'b1, 4'b0000, BASE | 32'h800c, 32'h0);
    check("pre_reset_rd", bus_if.data_sram_rdata, 32'h0022_0044);
    resetn = 1'b0;
    step(1'b1, 4'b0000, BASE | 32'h800c, 32'h0);
    check("midrst_rdata", bus_if.data_sram_rdata, 32'h0);
    check("midrst_led", {16'h0, led}, 32'h0000_ffff);
    resetn = 1'b1;

`ifdef CONFREG_TIMER_IRQ_EN
    step(1'b1, 4'b1111, BASE | 32'he004, 32'd10);
    check("tcmp_wr_old", bus_if.data_sram_rdata, 32'hffff_ffff);
    idle(9);
    check("irq_before", {31'h0, timer_irq}, 32'h0);
    idle(1);
    check("irq_set", {31'h0, timer_irq}, 32'h1);
    idle(3);
    check("irq_sticky", {31'h0, timer_irq}, 32'h1);
    step(1'b1, 4'b1111, BASE | 32'he004, 32'hffff_ffff);
    check("irq_clear", {31'h0, timer_irq}, 32'h0);
    step(1'b1, 4'b0000, BASE | 32'he004, 32'h0);
    check("tcmp_rd", bus_if.data_sram_rdata, 32'hffff_ffff);
`else
    step(1'b1, 4'b1111, BASE | 32'he004, 32'd10);
    check("tcmp_absent_wr", bus_if.data_sram_rdata, 32'h0);
    idle(12);
    check("irq_tied", {31'h0, timer_irq}, 32'h0);
    step(1'b1, 4'b0000, BASE | 32'he004, 32'h0);
    check("tcmp_absent_rd", bus_if.data_sram_rdata, 32'h0);
`endif

    step(1'b1, 4'b0000, BASE | 32'h800c, 32'h0);
    check("cr3_after_rst", bus_if.data_sram_rdata, 32'h0);
    idle(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
